operand_packer: RTL and testbench
=================================

Name: operand_packer

Overview:
- Front end for the adder_tree reduction stage. Accepts one operand per valid/ready beat and converts it to sign-magnitude Q(INT_W).(FRAC_W) format.
- Assembles N operands into the packed N*WIDTH bus that adder_tree consumes, then holds that vector with a valid/ready output handshake until it is taken.
- A flush input closes a partial vector early and zero-pads the unused slots.

Parameters:
- N, 8, operands per packed vector (>=2)
- WIDTH, 16, bits per operand; bit WIDTH-1 is the sign
- INT_W, 6, integer bits including sign (documentation only; the packer is format-transparent)
- FRAC_W, 10, fractional bits; INT_W+FRAC_W must equal WIDTH
- IN_TWOS, 0, 1 = in_data is two's complement and is converted; 0 = in_data is already sign-magnitude

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, in_data is valid this cycle
- in_ready, output, 1, packer accepts a beat this cycle
- in_data, input, WIDTH, operand
- flush, input, 1, single-cycle request to close the current partial vector
- out_valid, output, 1, packed vector available
- out_ready, input, 1, downstream takes the vector
- out_data, output, N*WIDTH, packed operands; slot k is [k*WIDTH +: WIDTH]
- out_count, output, clog2(N+1), number of real (non-pad) operands in out_data

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, slot index idx=0
  - out_data=0, out_valid=0, out_count=0
  - in_ready=1 once reset is released; in_ready is also held 0 while rst_n=0
- States: FILL, FULL.
- FILL:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid&&in_ready. The converted operand is written to slot idx and idx increments.
  - The first accepted operand goes to slot 0 (LSBs).
- Conversion when IN_TWOS=1:
  - Value >= 0: passed unchanged.
  - Value < 0: sign=1, magnitude=-value.
  - Most negative input (e.g. 0x8000): saturates to 0xFFFF, i.e. magnitude all ones, sign 1.
- Normalisation (both modes): negative zero (0x8000 after conversion) is stored as 0x0000.
- FILL -> FULL transitions (out_valid=1 from the following cycle):
  - Beat accepted with idx==N-1: out_count=N, idx wraps to 0.
  - flush=1 with idx>0 and no beat: slots idx..N-1 are cleared to 0, out_count=idx.
  - flush=1 together with an accepted beat: the beat is written first. Padding starts at idx+1 and out_count=idx+1. If that beat fills slot N-1, the result is identical to a normal fill.
  - flush with idx==0 and no beat: ignored, no empty vector is emitted.
- FULL:
  - in_ready=0, out_valid=1.
  - out_data and out_count are stable until the transfer.
  - flush is ignored.
  - out_valid&&out_ready: next cycle state=FILL, idx=0, out_valid=0, in_ready=1.
  - out_data keeps its old value until it is overwritten slot by slot. Consumers must use it only while out_valid=1.
- Latency and throughput:
  - Last beat accepted in cycle t -> out_valid=1 in cycle t+1.
  - Transfer in cycle t -> in_ready=1 in cycle t+1.
  - One bubble cycle per vector is accepted, giving N+1 cycles per vector at best.
- No combinational path from any input to in_ready or out_valid. All outputs are registered.
- Asynchronous reset mid-fill or in FULL discards the partial or held vector; no output is produced for it.
- in_valid while in_ready=0 is not accepted. The upstream source must hold the data.

Test Plan:
1. IN_TWOS=0, out_ready=1, feed 020a,0040,801b,81cc,83e1,04d7,0031,007a back-to-back.
   -> out_valid one cycle after the 8th beat; out_data={007a,0031,04d7,83e1,81cc,801b,0040,020a}; out_count=8; in_ready=0 for exactly one cycle.
2. IN_TWOS=0, feed 0040, 80f5, 7fff, then pulse flush alone.
   -> out_data[47:0]={7fff,80f5,0040}, upper 80 bits 0; out_count=3.
   - Variant: flush in the same cycle as the 3rd beat gives the same result.
3. IN_TWOS=1, feed FF0B, 8000, 0000, 00F5, then flush.
   -> slots = 80F5, FFFF, 0000, 00F5; out_count=4.
   - IN_TWOS=0 with input 8000 -> stored as 0000.
4. Backpressure: complete a vector with out_ready=0 for 5 cycles while in_valid stays 1.
   -> in_ready=0, out_data stable, no beat lost.
   - Raise out_ready -> one transfer; the next beat lands in slot 0 of the next vector.
5. Flush edge cases: flush with idx=0, and flush while FULL.
   -> no state change; out_valid stays as before.
6. Reset: assert rst_n=0 asynchronously after 5 beats (mid-cycle).
   -> out_valid=0, out_count=0, out_data=0 immediately.
   - After release, 8 fresh beats produce a correct vector with no residue from the aborted one.

Source files
------------

// File: rtl/operand_packer.sv
// Collects N operands into one packed vector in sign-magnitude form, with
// early close (flush, zero-padded) and a valid/ready hold on the output side.
module operand_packer #(
  parameter int N       = 8,
  parameter int WIDTH   = 16,
  parameter int INT_W   = 6,
  parameter int FRAC_W  = 10,
  parameter int IN_TWOS = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*WIDTH-1:0]       out_data,
  output logic [$clog2(N+1)-1:0]   out_count
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N+1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N-1);

  generate
    if (INT_W + FRAC_W != WIDTH) begin : g_format_check
      $error("operand_packer: INT_W + FRAC_W must equal WIDTH");
    end
  endgenerate

  typedef enum logic [0:0] {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N*WIDTH-1:0] data_q, data_d;
  logic               in_ready_q;
  logic               accept_s;
  logic               pad_s;
  logic [CNT_W-1:0]   pad_from_s;
  logic [WIDTH-1:0]   conv_s;

  // Two's complement to sign-magnitude (saturating the most negative value),
  // then folding negative zero onto +0 so the adder tree sees a single zero.
  function automatic logic [WIDTH-1:0] to_sign_mag(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] neg;
    logic [WIDTH-1:0] r;
    neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    r   = v;
    if ((IN_TWOS != 0) && v[WIDTH-1]) begin
      if (v[WIDTH-2:0] == {(WIDTH-1){1'b0}}) r = {WIDTH{1'b1}};
      else                                   r = {1'b1, neg[WIDTH-2:0]};
    end else begin
      r = v;
    end
    if (r == {1'b1, {(WIDTH-1){1'b0}}}) r = {WIDTH{1'b0}};
    else                                r = r;
    return r;
  endfunction

  assign conv_s   = to_sign_mag(in_data);
  assign accept_s = in_valid && in_ready_q && (state_q == FILL);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    pad_s      = 1'b0;
    pad_from_s = CNT_W'(idx_q);
    case (state_q)
      FILL: begin
        if (accept_s) begin
          data_d[idx_q*WIDTH +: WIDTH] = conv_s;
          if (idx_q == IDX_LAST) begin
            state_d = FULL;
            cnt_d   = CNT_W'(N);
            idx_d   = {IDX_W{1'b0}};
          end else if (flush) begin
            state_d    = FULL;
            cnt_d      = CNT_W'(idx_q) + CNT_ONE;
            pad_s      = 1'b1;
            pad_from_s = CNT_W'(idx_q) + CNT_ONE;
            idx_d      = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else if (flush && (idx_q != {IDX_W{1'b0}})) begin
          // Empty vectors are never emitted, so a flush at idx 0 falls through.
          state_d = FULL;
          cnt_d   = CNT_W'(idx_q);
          pad_s   = 1'b1;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = FILL;
        end
      end
      FULL: begin
        if (out_ready) state_d = FILL;
        else           state_d = FULL;
      end
      default: begin
        state_d = FILL;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
    for (int k = 0; k < N; k++) begin
      data_d[k*WIDTH +: WIDTH] = (pad_s && (CNT_W'(k) >= pad_from_s)) ?
                                 {WIDTH{1'b0}} : data_d[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      idx_q      <= {IDX_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      data_q     <= {(N*WIDTH){1'b0}};
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      in_ready_q <= (state_d == FILL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_operand_packer.sv
// Scoreboard bench for operand_packer: one instance per input format, shared
// stimulus gated by sel, expected vectors queued at drive time.
module tb_operand_packer;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic sel = 1'b0;
  logic [W-1:0] in_data = 16'h0000;
  logic v0, v1, f0, f1;
  logic in_ready0, out_valid0, in_ready1, out_valid1;
  logic [N*W-1:0] out_data0, out_data1;
  logic [CW-1:0] out_count0, out_count1;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [N*W-1:0] data;
    logic [CW-1:0]  cnt;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  assign v0 = in_valid & ~sel;
  assign f0 = flush & ~sel;
  assign v1 = in_valid & sel;
  assign f1 = flush & sel;

  always #5 clk = ~clk;

  operand_packer #(.N(N), .WIDTH(W), .INT_W(6), .FRAC_W(10), .IN_TWOS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(in_ready0), .in_data(in_data),
    .flush(f0), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_count(out_count0));

  operand_packer #(.N(N), .WIDTH(W), .INT_W(6), .FRAC_W(10), .IN_TWOS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(in_ready1), .in_data(in_data),
    .flush(f1), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_count(out_count1));

  // Pop and compare on every output handshake of the sign-magnitude instance.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) begin
      total_cnt++;
      if (sb0.size() == 0) begin
        $display("FAIL sb0_unexpected: got vector %h count %0d, required none", out_data0, out_count0);
      end else begin
        e0 = sb0.pop_front();
        if (out_data0 !== e0.data || out_count0 !== e0.cnt)
          $display("FAIL sb0_vector: got %h/%0d, required %h/%0d", out_data0, out_count0, e0.data, e0.cnt);
        else pass_cnt++;
      end
    end
  end

  // Same for the two's-complement instance.
  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready) begin
      total_cnt++;
      if (sb1.size() == 0) begin
        $display("FAIL sb1_unexpected: got vector %h count %0d, required none", out_data1, out_count1);
      end else begin
        e1 = sb1.pop_front();
        if (out_data1 !== e1.data || out_count1 !== e1.cnt)
          $display("FAIL sb1_vector: got %h/%0d, required %h/%0d", out_data1, out_count1, e1.data, e1.cnt);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] model_sm(input logic [W-1:0] v, input bit twos);
    int s;
    logic [W-1:0] r;
    r = v;
    if (twos) begin
      s = int'($signed(v));
      if (s == -32768) r = 16'hFFFF;
      else if (s < 0) r = 16'h8000 | W'(-s);
    end
    if (r == 16'h8000) r = 16'h0000;
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic fl);
    in_valid = 1'b1; in_data = d; flush = fl;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_flush;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #2;
    total_cnt++; if ({in_ready0, out_valid0} !== 2'b00) $display("FAIL rst_hs: got %b, required 00", {in_ready0, out_valid0}); else pass_cnt++;
    total_cnt++; if (out_count0 !== 4'd0) $display("FAIL rst_count: got %0d, required 0", out_count0); else pass_cnt++;
    total_cnt++; if (out_data0 !== 128'h0) $display("FAIL rst_data: got %h, required 0", out_data0); else pass_cnt++;
    #10 rst_n = 1'b1;
    #1;
    total_cnt++; if (in_ready0 !== 1'b0) $display("FAIL rst_ready_pre_edge: got %b, required 0", in_ready0); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if ({in_ready0, in_ready1, out_valid0} !== 3'b110) $display("FAIL rst_release: got %b, required 110", {in_ready0, in_ready1, out_valid0}); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d [8] = '{16'h020a, 16'h0040, 16'h801b, 16'h81cc, 16'h83e1, 16'h04d7, 16'h0031, 16'h007a};
    sel = 1'b0; out_ready = 1'b1;
    sb0.push_back('{data: 128'h007a_0031_04d7_83e1_81cc_801b_0040_020a, cnt: 4'd8});
    for (int k = 0; k < 8; k++) begin
      total_cnt++; if (in_ready0 !== 1'b1) $display("FAIL b2b_ready_beat%0d: got %b, required 1", k, in_ready0); else pass_cnt++;
      in_valid = 1'b1; in_data = d[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total_cnt++; if ({out_valid0, in_ready0} !== 2'b10) $display("FAIL b2b_full: got %b, required 10", {out_valid0, in_ready0}); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if ({out_valid0, in_ready0} !== 2'b01) $display("FAIL b2b_bubble: got %b, required 01", {out_valid0, in_ready0}); else pass_cnt++;
  endtask

  task automatic test_flush_with_beat;
    sel = 1'b0; out_ready = 1'b1;
    sb0.push_back('{data: {80'h0, 16'h7fff, 16'h80f5, 16'h0040}, cnt: 4'd3});
    send(16'h0040, 1'b0); send(16'h80f5, 1'b0); send(16'h7fff, 1'b1);
    total_cnt++; if (out_valid0 !== 1'b1) $display("FAIL flush_beat_valid: got %b, required 1", out_valid0); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_flush_alone;
    sel = 1'b0; out_ready = 1'b1;
    sb0.push_back('{data: {80'h0, 16'h7fff, 16'h80f5, 16'h0040}, cnt: 4'd3});
    send(16'h0040, 1'b0); send(16'h80f5, 1'b0); send(16'h7fff, 1'b0);
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL flush_pre_valid: got %b, required 0", out_valid0); else pass_cnt++;
    pulse_flush();
    total_cnt++; if (out_valid0 !== 1'b1 || out_count0 !== 4'd3) $display("FAIL flush_alone: got %b/%0d, required 1/3", out_valid0, out_count0); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_random(input logic s, input int nvec);
    logic [W-1:0] d [8];
    logic [N*W-1:0] ev;
    sel = s; out_ready = 1'b1;
    for (int v = 0; v < nvec; v++) begin
      for (int k = 0; k < 8; k++) begin
        d[k] = W'($urandom);
        if (k == 3) d[k] = 16'h8000;
        ev[k*W +: W] = model_sm(d[k], s);
      end
      if (s) sb1.push_back('{data: ev, cnt: 4'd8});
      else   sb0.push_back('{data: ev, cnt: 4'd8});
      for (int k = 0; k < 8; k++) send(d[k], 1'b0);
      idle(1);
    end
    sel = 1'b0;
  endtask

  task automatic test_twos;
    sel = 1'b1; out_ready = 1'b1;
    sb1.push_back('{data: {64'h0, 16'h00F5, 16'h0000, 16'hFFFF, 16'h80F5}, cnt: 4'd4});
    send(16'hFF0B, 1'b0); send(16'h8000, 1'b0); send(16'h0000, 1'b0); send(16'h00F5, 1'b0);
    pulse_flush();
    total_cnt++; if (out_valid1 !== 1'b1 || out_count1 !== 4'd4) $display("FAIL twos_close: got %b/%0d, required 1/4", out_valid1, out_count1); else pass_cnt++;
    idle(1);
    sel = 1'b0;
    sb0.push_back('{data: 128'h0, cnt: 4'd1});
    send(16'h8000, 1'b1);
    total_cnt++; if (out_data0 !== 128'h0) $display("FAIL negzero_sm: got %h, required 0", out_data0); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_backpressure;
    logic [N*W-1:0] ev;
    sel = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) ev[k*W +: W] = W'(16'h1111 * (k + 1));
    sb0.push_back('{data: ev, cnt: 4'd8});
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = W'(16'h1111 * (k + 1));
      @(posedge clk); #1;
    end
    in_data = 16'h9999;
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if ({in_ready0, out_valid0} !== 2'b01 || out_data0 !== ev) $display("FAIL bp_hold_c%0d: got %b %h, required 01 %h", c, {in_ready0, out_valid0}, out_data0, ev); else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if ({in_ready0, out_valid0} !== 2'b10) $display("FAIL bp_release: got %b, required 10", {in_ready0, out_valid0}); else pass_cnt++;
    sb0.push_back('{data: {112'h0, 16'h9999}, cnt: 4'd1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulse_flush();
    total_cnt++; if (out_valid0 !== 1'b1) $display("FAIL bp_next_valid: got %b, required 1", out_valid0); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_flush_edges;
    logic [N*W-1:0] ev;
    sel = 1'b0; out_ready = 1'b1;
    pulse_flush();
    total_cnt++; if ({out_valid0, in_ready0} !== 2'b01) $display("FAIL flush_idx0: got %b, required 01", {out_valid0, in_ready0}); else pass_cnt++;
    idle(2);
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) ev[k*W +: W] = W'(16'h0123 + k);
    sb0.push_back('{data: ev, cnt: 4'd8});
    for (int k = 0; k < 8; k++) send(W'(16'h0123 + k), 1'b0);
    pulse_flush();
    total_cnt++; if (out_valid0 !== 1'b1 || out_count0 !== 4'd8 || out_data0 !== ev) $display("FAIL flush_full: got %b/%0d %h, required 1/8 %h", out_valid0, out_count0, out_data0, ev); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL flush_full_xfer: got %b, required 0", out_valid0); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    logic [N*W-1:0] ev;
    sel = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send(W'(16'h0a00 + k), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    total_cnt++; if ({out_valid0, in_ready0} !== 2'b00 || out_count0 !== 4'd0 || out_data0 !== 128'h0) $display("FAIL async_rst: got %b/%0d %h, required 00/0 0", {out_valid0, in_ready0}, out_count0, out_data0); else pass_cnt++;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (in_ready0 !== 1'b1) $display("FAIL async_rst_release: got %b, required 1", in_ready0); else pass_cnt++;
    for (int k = 0; k < 8; k++) ev[k*W +: W] = W'(16'h0b10 + k);
    sb0.push_back('{data: ev, cnt: 4'd8});
    for (int k = 0; k < 8; k++) send(W'(16'h0b10 + k), 1'b0);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_flush_with_beat();
    test_random(1'b0, 2);
    test_flush_alone();
    test_twos();
    test_random(1'b1, 2);
    test_backpressure();
    test_flush_edges();
    test_async_reset();
    idle(3);
    total_cnt++;
    if (sb0.size() != 0 || sb1.size() != 0) $display("FAIL sb_drain: got %0d/%0d pending, required 0/0", sb0.size(), sb1.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
